branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Control-step sequencer for the execute phase of conditional-branch instructions (brzr, brnz, brpl, brmi).
- Once the control unit has fetched and decoded a branch, this block walks steps T3..T6.
- Each step drives the register-file, PC, Y, C-sign-extend, ALU and Z enables, plus the CON flip-flop load/clear.
- PC is written only when the CON flip-flop reports the condition true.
- Keeps taken / not-taken performance counters for the branch unit.

Parameters:
- CNT_W, 16, width of the taken_count / not_taken_count performance counters.
- ALU_OP_W, 5, width of the ALU opcode bus.
- ALU_ADD, 5'b00011, ALU opcode driven in T5 (PC + C).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request: decoded instruction is a conditional branch.
- ir_c2  in  2  condition field C2 of the IR, sampled with start.
- con_ff  in  1  CON flip-flop output (condition result).
- abort  in  1  synchronous abort of an in-progress sequence.
- busy  out  1  high in every state except IDLE.
- cond_sel  out  2  registered C2 presented to the CON decoder.
- con_clear  out  1  clears CON before evaluation.
- gra  out  1  select Ra field for the register file.
- r_out  out  1  selected register onto bus.
- con_in  out  1  CON flip-flop load enable.
- pc_out  out  1  PC onto bus.
- y_in  out  1  Y register load.
- c_out  out  1  sign-extended C onto bus.
- alu_op  out  ALU_OP_W  ALU opcode; ALU_ADD in T5, 0 otherwise.
- z_in  out  1  Z register load.
- zlow_out  out  1  Zlow onto bus.
- pc_in  out  1  PC load enable.
- done  out  1  one-cycle completion pulse.
- taken  out  1  registered result of the last completed branch.
- taken_count  out  CNT_W  completed taken branches.
- not_taken_count  out  CNT_W  completed not-taken branches.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, cond_sel=0, taken=0, both counters=0.
  - All step outputs are low and alu_op=0.
  - Reset has priority over abort and start and is honoured in any state.
- States and transitions: IDLE -> T3 -> T4 -> T5 -> T6 -> IDLE. One cycle per state, no waits.
- IDLE:
  - busy=0.
  - On start=1: cond_sel<=ir_c2, next state T3, and con_clear=1 combinationally in that same cycle.
  - start=0: stay in IDLE.
- T3: gra=1, r_out=1, con_in=1.
- T4: pc_out=1, y_in=1.
- T5: c_out=1, alu_op=ALU_ADD, z_in=1.
- T6:
  - zlow_out=1, done=1.
  - pc_in=con_ff, sampled combinationally in T6.
  - At the clock edge: taken<=con_ff, and taken_count or not_taken_count increments by 1.
- Step outputs:
  - Moore-decoded from state, except pc_in (gated by con_ff) and con_clear (gated by start in IDLE).
  - Exactly the listed signals are high in each state; all others are 0.
- Latency: start to done = 4 cycles (done is high in the 4th cycle after the start cycle). Throughput is one branch per 5 cycles.
- Back-to-back: start may be asserted in the cycle after T6, i.e. the first IDLE cycle.
- start while busy=1: ignored, no queuing; cond_sel is unchanged.
- abort:
  - In T3..T6: next state IDLE.
  - If asserted in T6, pc_in is suppressed (forced 0) that cycle, done=0, and the counters and taken are not updated.
  - abort in IDLE: no effect. abort with start in IDLE: abort wins and the sequence does not start.
- Counters wrap modulo 2^CNT_W (all-ones + 1 -> 0).
- ir_c2 encoding (decoded by the CON logic, passed through here): 00 zero, 01 nonzero, 10 positive (>=0), 11 negative.

Decomposition:
- Shared package br_ctrl_pkg holds:
  - the state enum (IDLE, T3, T4, T5, T6, 3-bit encoding);
  - the ALU opcode constants, including ALU_ADD;
  - the C2 condition codes (COND_ZR, COND_NZ, COND_PL, COND_MI).
- One sub-module: perf_counter (CNT_W-bit, sync active-low reset, increment enable), instantiated twice.
- The FSM and output decode stay in branch_sequencer.

Test Plan:
- brzr taken: reset, start=1 with ir_c2=00, drive con_ff=1 from T4.
  - Expect cond_sel=00 and con_clear=1 in the start cycle.
  - T3: gra, r_out, con_in. T4: pc_out, y_in. T5: c_out, z_in, alu_op=00011.
  - T6: zlow_out, pc_in=1, done=1. Then taken=1, taken_count=1, not_taken_count=0.
- brnz not taken: ir_c2=01, con_ff=0 → T6 has pc_in=0 and done=1; taken=0; not_taken_count increments to 1.
- Back-to-back and ignore:
  - start held high continuously → a new sequence begins every 5 cycles.
  - Changing ir_c2 in T4 does not change cond_sel.
- Abort: assert abort in T5 → next cycle IDLE, busy=0. No T6, no done, no pc_in, counters unchanged.
- Abort in T6 with con_ff=1 → pc_in=0, done=0, counters unchanged.
- Reset mid-operation: reset_n=0 in T4 → next cycle IDLE, all outputs 0, counters 0. A fresh start then runs normally.
- Counter wrap: CNT_W=2, run 5 taken branches → taken_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/br_ctrl_pkg.sv
// br_ctrl_pkg: shared state encoding, ALU opcodes and C2 condition codes for branch control
package br_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, T3, T4, T5, T6} state_t;
    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [1:0] COND_ZR = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_PL = 2'b10;
    localparam logic [1:0] COND_MI = 2'b11;
endpackage

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: control-unit request and datapath step-enable bundle
interface branch_sequencer_if #(
    parameter int CNT_W    = 16,
    parameter int ALU_OP_W = 5
);
    logic                start;
    logic [1:0]          ir_c2;
    logic                con_ff;
    logic                abort;
    logic                busy;
    logic [1:0]          cond_sel;
    logic                con_clear;
    logic                gra;
    logic                r_out;
    logic                con_in;
    logic                pc_out;
    logic                y_in;
    logic                c_out;
    logic [ALU_OP_W-1:0] alu_op;
    logic                z_in;
    logic                zlow_out;
    logic                pc_in;
    logic                done;
    logic                taken;
    logic [CNT_W-1:0]    taken_count;
    logic [CNT_W-1:0]    not_taken_count;

    modport master (
        output start, ir_c2, con_ff, abort,
        input  busy, cond_sel, con_clear, gra, r_out, con_in, pc_out, y_in, c_out,
               alu_op, z_in, zlow_out, pc_in, done, taken, taken_count, not_taken_count
    );

    modport slave (
        input  start, ir_c2, con_ff, abort,
        output busy, cond_sel, con_clear, gra, r_out, con_in, pc_out, y_in, c_out,
               alu_op, z_in, zlow_out, pc_in, done, taken, taken_count, not_taken_count
    );
endinterface

// File: rtl/perf_counter.sv
// perf_counter: wrapping event counter with enable
module perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clock) begin
        if (!reset_n) count <= '0;
        else if (en) count <= count + 1'b1;
    end
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: T3..T6 execute-phase step sequencer for conditional branches
module branch_sequencer #(
    parameter int                  CNT_W    = 16,
    parameter int                  ALU_OP_W = 5,
    parameter logic [ALU_OP_W-1:0] ALU_ADD  = br_ctrl_pkg::ALU_ADD
) (
    input logic               clock,
    input logic               reset_n,
    branch_sequencer_if.slave bus
);
    import br_ctrl_pkg::*;

    state_t state;
    logic   t6_ok;

    assign t6_ok         = (state == T6) && !bus.abort;
    assign bus.con_clear = (state == IDLE) && bus.start && !bus.abort;
    assign bus.zlow_out  = (state == T6);
    assign bus.done      = t6_ok;
    assign bus.pc_in     = t6_ok && bus.con_ff;

    always_ff @(posedge clock) begin
        {bus.gra, bus.r_out, bus.con_in, bus.pc_out, bus.y_in, bus.c_out, bus.z_in} <= '0;
        bus.alu_op <= '0;
        bus.busy <= 1'b0;
        if (!reset_n) begin
            state <= IDLE;
            bus.cond_sel <= '0;
            bus.taken <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start && !bus.abort) begin
                state <= T3;
                bus.cond_sel <= bus.ir_c2;
                bus.busy <= 1'b1;
                {bus.gra, bus.r_out, bus.con_in} <= '1;
            end
        end else if (bus.abort) begin
            state <= IDLE;
        end else begin
            case (state)
                T3: begin
                    state <= T4;
                    bus.busy <= 1'b1;
                    {bus.pc_out, bus.y_in} <= '1;
                end
                T4: begin
                    state <= T5;
                    bus.busy <= 1'b1;
                    {bus.c_out, bus.z_in} <= '1;
                    bus.alu_op <= ALU_ADD;
                end
                T5: begin
                    state <= T6;
                    bus.busy <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    bus.taken <= bus.con_ff;
                end
            endcase
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_taken (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (t6_ok && bus.con_ff),
        .count   (bus.taken_count)
    );

    perf_counter #(.CNT_W(CNT_W)) u_not_taken (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (t6_ok && !bus.con_ff),
        .count   (bus.not_taken_count)
    );
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: scoreboard bench, per-cycle expected output vectors checked by a monitor
module tb_branch_sequencer;
    import br_ctrl_pkg::*;

    localparam int          CW    = 2;
    localparam logic [23:0] ALL   = 24'hFF_FFFF;
    localparam logic [23:0] NO_CC = 24'hEF_FFFF;
    localparam logic [10:0] S_NONE = 11'b000_0000_0000;
    localparam logic [10:0] S_CC   = 11'b100_0000_0000;
    localparam logic [10:0] S_T3   = 11'b011_1000_0000;
    localparam logic [10:0] S_T4   = 11'b000_0110_0000;
    localparam logic [10:0] S_T5   = 11'b000_0001_1000;
    localparam logic [10:0] S_T6   = 11'b000_0000_0101;
    localparam logic [10:0] S_ZL   = 11'b000_0000_0100;
    localparam logic [10:0] S_PC   = 11'b000_0000_0010;

    typedef struct {
        string       nm;
        logic [23:0] v;
        logic [23:0] m;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  m_cs = 2'b00;
    logic        m_tk = 1'b0;
    logic [1:0]  m_tc = 2'b00;
    logic [1:0]  m_ntc = 2'b00;
    logic [23:0] act;

    branch_sequencer_if #(.CNT_W(CW), .ALU_OP_W(5)) bus ();

    branch_sequencer #(.CNT_W(CW), .ALU_OP_W(5), .ALU_ADD(ALU_ADD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    assign act = {bus.busy, bus.cond_sel, bus.con_clear, bus.gra, bus.r_out, bus.con_in,
                  bus.pc_out, bus.y_in, bus.c_out, bus.z_in, bus.zlow_out, bus.pc_in, bus.done,
                  bus.alu_op, bus.taken, bus.taken_count, bus.not_taken_count};

    function automatic logic [23:0] mk(input logic b, input logic [1:0] cs, input logic [10:0] st,
                                       input logic [4:0] alu, input logic tk,
                                       input logic [1:0] tc, input logic [1:0] ntc);
        return {b, cs, st, alu, tk, tc, ntc};
    endfunction

    task automatic cyc(input string nm, input logic s, input logic [1:0] c2, input logic con,
                       input logic ab, input logic rn, input logic [23:0] v, input logic [23:0] m);
        exp_t e;
        @(posedge clock);
        #1;
        bus.start  = s;
        bus.ir_c2  = c2;
        bus.con_ff = con;
        bus.abort  = ab;
        reset_n    = rn;
        e.nm = nm;
        e.v  = v;
        e.m  = m;
        q.push_back(e);
    endtask

    task automatic run_branch(input string nm, input logic [1:0] c2, input logic con,
                              input int ab_at, input bit b2b);
        logic [10:0] st6;
        cyc({nm, "/idle"}, 1'b1, c2, 1'b0, 1'b0, 1'b1, mk(1'b0, m_cs, S_CC, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
        m_cs = c2;
        cyc({nm, "/t3"}, 1'b1, c2, 1'b0, 1'b0, 1'b1, mk(1'b1, c2, S_T3, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
        cyc({nm, "/t4"}, 1'b1, ~c2, con, 1'b0, 1'b1, mk(1'b1, c2, S_T4, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
        cyc({nm, "/t5"}, 1'b1, ~c2, con, ab_at == 5, 1'b1, mk(1'b1, c2, S_T5, ALU_ADD, m_tk, m_tc, m_ntc), ALL);
        if (ab_at != 5) begin
            st6 = (ab_at == 6) ? S_ZL : (con ? (S_T6 | S_PC) : S_T6);
            cyc({nm, "/t6"}, 1'b1, c2, con, ab_at == 6, 1'b1, mk(1'b1, c2, st6, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
            if (ab_at != 6) begin
                m_tk = con;
                if (con) m_tc = m_tc + 2'd1;
                else m_ntc = m_ntc + 2'd1;
            end
        end
        if (!b2b)
            cyc({nm, "/end"}, 1'b0, c2, 1'b0, 1'b0, 1'b1, mk(1'b0, c2, S_NONE, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
    endtask

    always @(negedge clock) begin
        if (q.size() != 0) begin
            e_mon = q.pop_front();
            n_tests++;
            if ((act & e_mon.m) !== (e_mon.v & e_mon.m)) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e_mon.nm, act & e_mon.m, e_mon.v & e_mon.m);
            end
        end
    end

    initial begin
        bus.start  = 1'b0;
        bus.ir_c2  = 2'b00;
        bus.con_ff = 1'b0;
        bus.abort  = 1'b0;
        cyc("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, mk(1'b0, 2'b00, S_NONE, ALU_NOP, 1'b0, 2'd0, 2'd0), ALL);
        cyc("reset_release", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, mk(1'b0, 2'b00, S_NONE, ALU_NOP, 1'b0, 2'd0, 2'd0), ALL);
        run_branch("brzr_taken", COND_ZR, 1'b1, 0, 1'b0);
        run_branch("brnz_not_taken", COND_NZ, 1'b0, 0, 1'b0);
        run_branch("b2b_pl", COND_PL, 1'b1, 0, 1'b1);
        run_branch("b2b_mi", COND_MI, 1'b0, 0, 1'b1);
        run_branch("b2b_pl2", COND_PL, 1'b1, 0, 1'b0);
        run_branch("abort_t5", COND_NZ, 1'b1, 5, 1'b0);
        run_branch("abort_t6", COND_ZR, 1'b1, 6, 1'b0);
        cyc("idle_abort", 1'b0, COND_MI, 1'b0, 1'b1, 1'b1, mk(1'b0, m_cs, S_NONE, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
        cyc("start_abort", 1'b1, m_cs, 1'b0, 1'b1, 1'b1, mk(1'b0, m_cs, S_NONE, ALU_NOP, m_tk, m_tc, m_ntc), NO_CC);
        cyc("start_abort_next", 1'b0, m_cs, 1'b0, 1'b0, 1'b1, mk(1'b0, m_cs, S_NONE, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
        cyc("rst_idle", 1'b1, COND_MI, 1'b0, 1'b0, 1'b1, mk(1'b0, m_cs, S_CC, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
        m_cs = COND_MI;
        cyc("rst_t3", 1'b0, COND_MI, 1'b0, 1'b0, 1'b1, mk(1'b1, m_cs, S_T3, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
        cyc("rst_t4", 1'b0, COND_MI, 1'b1, 1'b0, 1'b0, mk(1'b1, m_cs, S_T4, ALU_NOP, m_tk, m_tc, m_ntc), ALL);
        m_cs  = 2'b00;
        m_tk  = 1'b0;
        m_tc  = 2'd0;
        m_ntc = 2'd0;
        cyc("rst_after", 1'b0, COND_MI, 1'b0, 1'b0, 1'b1, mk(1'b0, 2'b00, S_NONE, ALU_NOP, 1'b0, 2'd0, 2'd0), ALL);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] c;
            c = i[1:0];
            run_branch($sformatf("wrap%0d", i), c, 1'b1, 0, 1'b0);
        end
        @(negedge clock);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
